// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the MUX scan sequencer and its channel finder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_scan_pkg;

    localparam int NUM_CHANNELS = 32;
    localparam int SEL_WIDTH    = 5;
    localparam int CNT_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_next_channel.sv
// Combinational priority finder: lowest set mask bit, or lowest set bit above cur_sel.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: mask (channel enables), cur_sel (channel just sampled), first (ignore cur_sel),
//        next_idx (selected channel), found (a candidate exists).
module mux_scan_next_channel
    import mux_scan_pkg::*;
(
    input  logic [NUM_CHANNELS-1:0] mask,
    input  logic [SEL_WIDTH-1:0]    cur_sel,
    input  logic                    first,
    output logic [SEL_WIDTH-1:0]    next_idx,
    output logic                    found
);

    // Descending loop: the last hit written is the lowest qualifying index.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (first || (SEL_WIDTH'(i) > cur_sel))) begin
                next_idx = SEL_WIDTH'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks enabled channels of a 32:1 MUX, settles, samples each into a snapshot word.
// Latency: E*(SETTLE_CYCLES+1) cycles from Start acceptance to Valid (0 extra for empty mask).
// Backpressure: word held in DONE until Valid&&Ready; Start ignored while busy or unacknowledged.
// Ports: Clock_In/Reset_N_In, Start_In/Abort_In/Channel_Mask_In control, Mux_* to/from the MUX,
//        Busy_Out status, Word_Valid_Out/Word_Ready_In/Word_Data_Out snapshot handshake.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    Clock_In,
    input  logic                    Reset_N_In,
    input  logic                    Start_In,
    input  logic                    Abort_In,
    input  logic [NUM_CHANNELS-1:0] Channel_Mask_In,
    input  logic                    Mux_Data_In,
    output logic                    Mux_Enable_Out,
    output logic [SEL_WIDTH-1:0]    Mux_Select_Out,
    output logic                    Busy_Out,
    output logic                    Word_Valid_Out,
    input  logic                    Word_Ready_In,
    output logic [NUM_CHANNELS-1:0] Word_Data_Out
);

    // With zero settle time each channel goes straight to its sampling cycle.
    localparam state_t CHAN_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST =
        CNT_WIDTH'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t                  state_q, state_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;

    logic                    start_ok;
    logic                    find_first;
    logic [NUM_CHANNELS-1:0] find_mask;
    logic [SEL_WIDTH-1:0]    find_idx;
    logic                    find_found;

    // A new scan searches the incoming mask from channel 0; an ongoing scan
    // searches the captured mask above the channel just sampled.
    assign find_first = (state_q == IDLE) || (state_q == DONE);
    assign find_mask  = find_first ? Channel_Mask_In : mask_q;

    mux_scan_next_channel u_next_channel (
        .mask     (find_mask),
        .cur_sel  (sel_q),
        .first    (find_first),
        .next_idx (find_idx),
        .found    (find_found)
    );

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        start_ok = 1'b0;

        case (state_q)
            IDLE: begin
                start_ok = Start_In;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            SAMPLE: begin
                // Only place the MUX output is captured, and enable is high here.
                data_d[sel_q] = Mux_Data_In;
                if (find_found) begin
                    sel_d   = find_idx;
                    cnt_d   = '0;
                    state_d = CHAN_ENTRY;
                end else begin
                    sel_d   = '0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (Word_Ready_In) begin
                    start_ok = Start_In;
                    if (!Start_In) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_ok) begin
            mask_d  = Channel_Mask_In;
            data_d  = '0;
            cnt_d   = '0;
            if (find_found) begin
                sel_d   = find_idx;
                valid_d = 1'b0;
                state_d = CHAN_ENTRY;
            end else begin
                // Empty mask: an all-zero word is complete immediately.
                sel_d   = '0;
                valid_d = 1'b1;
                state_d = DONE;
            end
        end

        if (Abort_In) begin
            state_d = IDLE;
            sel_d   = '0;
            cnt_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end
    end

    // All outputs come straight from flops (or a decode of the state flop).
    assign Busy_Out       = (state_q == SETTLE) || (state_q == SAMPLE);
    assign Mux_Enable_Out = Busy_Out;
    assign Mux_Select_Out = sel_q;
    assign Word_Valid_Out = valid_q;
    assign Word_Data_Out  = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: one instance with 2 settle cycles, one with 0.
// Latency: n/a.
// Backpressure: Ready driven per scenario.
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [31:0] mask = '0, pattern = '0;
    logic        mux_data, mux_en, busy, valid;
    logic [4:0]  mux_sel;
    logic [31:0] data;

    logic        start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b1;
    logic [31:0] mask0 = '0, pattern0 = '0;
    logic        mux_data0, mux_en0, busy0, valid0;
    logic [4:0]  mux_sel0;
    logic [31:0] data0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // MUX models: undriven-looking output while disabled.
    assign mux_data  = mux_en  ? pattern[mux_sel]   : 1'bx;
    assign mux_data0 = mux_en0 ? pattern0[mux_sel0] : 1'bx;

    mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut (
        .Clock_In(clk), .Reset_N_In(rst_n), .Start_In(start), .Abort_In(abort),
        .Channel_Mask_In(mask), .Mux_Data_In(mux_data), .Mux_Enable_Out(mux_en),
        .Mux_Select_Out(mux_sel), .Busy_Out(busy), .Word_Valid_Out(valid),
        .Word_Ready_In(ready), .Word_Data_Out(data)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(0)) dut0 (
        .Clock_In(clk), .Reset_N_In(rst_n), .Start_In(start0), .Abort_In(abort0),
        .Channel_Mask_In(mask0), .Mux_Data_In(mux_data0), .Mux_Enable_Out(mux_en0),
        .Mux_Select_Out(mux_sel0), .Busy_Out(busy0), .Word_Valid_Out(valid0),
        .Word_Ready_In(ready0), .Word_Data_Out(data0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present Start for one edge; returns just after the acceptance edge.
    task automatic do_start(input logic [31:0] m);
        mask  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        tests_run++;
        if ({mux_en, mux_sel, busy, valid} !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: en=%b sel=%0d busy=%b valid=%b expected all 0",
                     mux_en, mux_sel, busy, valid);
        end
        tests_run++;
        if (data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 00000000", data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_scan();
        int errs = 0;
        pattern = 32'hA5A5_A5A5;
        ready   = 1'b1;
        do_start(32'hFFFF_FFFF);
        for (int n = 0; n < 96; n++) begin
            if (!mux_en || !busy || valid || (mux_sel !== 5'(n / 3))) errs++;
            step();
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL full_walk: %0d bad cycles, expected 0", errs);
        end
        tests_run++;
        if (valid !== 1'b1 || data !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL full_word: valid=%b data=%h expected valid=1 data=a5a5a5a5", valid, data);
        end
        tests_run++;
        if (mux_en !== 1'b0 || mux_sel !== 5'd0) begin
            tests_failed++;
            $display("FAIL full_mux_idle: en=%b sel=%0d expected 0/0", mux_en, mux_sel);
        end
        step();
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_handshake: valid=%b expected 0", valid);
        end
    endtask

    task automatic test_sparse();
        int          cnt = 0;
        logic [31:0] seen = '0;
        pattern = 32'hFFFF_FFFF;
        ready   = 1'b1;
        do_start(32'h8000_0001);
        while (!valid && cnt < 200) begin
            if (mux_en) seen[mux_sel] = 1'b1;
            step();
            cnt++;
        end
        tests_run++;
        if (cnt != 6) begin
            tests_failed++;
            $display("FAIL sparse_latency: got %0d cycles expected 6", cnt);
        end
        tests_run++;
        if (seen !== 32'h8000_0001) begin
            tests_failed++;
            $display("FAIL sparse_selects: got %h expected 80000001", seen);
        end
        tests_run++;
        if (data !== 32'h8000_0001) begin
            tests_failed++;
            $display("FAIL sparse_data: got %h expected 80000001", data);
        end
        step();
    endtask

    task automatic test_zero_mask();
        pattern = 32'hFFFF_FFFF;
        ready   = 1'b1;
        do_start(32'h0);
        tests_run++;
        if (valid !== 1'b1 || data !== 32'd0 || mux_en !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_mask: valid=%b data=%h en=%b busy=%b expected 1/0/0/0",
                     valid, data, mux_en, busy);
        end
        step();
        tests_run++;
        if (valid !== 1'b0 || mux_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_mask_ack: valid=%b en=%b expected 0/0", valid, mux_en);
        end
    endtask

    task automatic test_hold_and_restart();
        int cnt = 0;
        int errs = 0;
        pattern = 32'h0000_000A;
        ready   = 1'b0;
        do_start(32'h0000_000F);
        mask = 32'hFFFF_FFFF;
        while (!valid && cnt < 200) begin
            start = (cnt == 4);
            step();
            start = 1'b0;
            cnt++;
        end
        tests_run++;
        if (cnt != 12 || data !== 32'h0000_000A) begin
            tests_failed++;
            $display("FAIL hold_first_scan: cycles=%0d data=%h expected 12 / 0000000a", cnt, data);
        end
        for (int n = 0; n < 10; n++) begin
            start = (n == 5);
            step();
            start = 1'b0;
            if (valid !== 1'b1 || data !== 32'h0000_000A || busy !== 1'b0) errs++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL hold_stable: %0d bad cycles expected 0", errs);
        end
        ready = 1'b1;
        do_start(32'h0000_0003);
        tests_run++;
        if (valid !== 1'b0 || busy !== 1'b1 || mux_sel !== 5'd0 || mux_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_edge: valid=%b busy=%b sel=%0d en=%b expected 0/1/0/1",
                     valid, busy, mux_sel, mux_en);
        end
        cnt = 0;
        while (!valid && cnt < 200) begin
            step();
            cnt++;
        end
        tests_run++;
        if (cnt != 6 || data !== 32'h0000_0002) begin
            tests_failed++;
            $display("FAIL restart_scan: cycles=%0d data=%h expected 6 / 00000002", cnt, data);
        end
        step();
    endtask

    task automatic test_abort();
        pattern = 32'hFFFF_FFFF;
        ready   = 1'b1;
        do_start(32'hFFFF_FFFF);
        repeat (40) step();
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        tests_run++;
        if ({mux_en, mux_sel, busy, valid} !== 8'd0 || data !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_state: en=%b sel=%0d busy=%b valid=%b data=%h expected all 0",
                     mux_en, mux_sel, busy, valid, data);
        end
        step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_queue: busy=%b expected 0", busy);
        end
        do_start(32'hFFFF_FFFF);
        tests_run++;
        if (mux_en !== 1'b1 || mux_sel !== 5'd0) begin
            tests_failed++;
            $display("FAIL abort_rescan: en=%b sel=%0d expected 1/0", mux_en, mux_sel);
        end
        repeat (3) step();
        tests_run++;
        if (mux_sel !== 5'd1) begin
            tests_failed++;
            $display("FAIL abort_rescan_next: sel=%0d expected 1", mux_sel);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_zero_settle();
        int errs = 0;
        pattern0 = 32'h1234_5678;
        ready0   = 1'b1;
        mask0    = 32'hFFFF_FFFF;
        start0   = 1'b1;
        step();
        start0   = 1'b0;
        for (int n = 0; n < 32; n++) begin
            if (!mux_en0 || valid0 || (mux_sel0 !== 5'(n))) errs++;
            step();
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL zero_settle_walk: %0d bad cycles expected 0", errs);
        end
        tests_run++;
        if (valid0 !== 1'b1 || data0 !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL zero_settle_word: valid=%b data=%h expected 1 / 12345678", valid0, data0);
        end
        step();
    endtask

    task automatic test_async_reset();
        pattern = 32'hFFFF_FFFF;
        ready   = 1'b1;
        do_start(32'hFFFF_FFFF);
        repeat (5) step();
        tests_run++;
        if (mux_sel !== 5'd1 || data[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre: sel=%0d data=%h expected sel 1 with bit0 set", mux_sel, data);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mux_en, mux_sel, busy, valid} !== 8'd0 || data !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_reset: en=%b sel=%0d busy=%b valid=%b data=%h expected all 0",
                     mux_en, mux_sel, busy, valid, data);
        end
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        step();
        test_reset();
        test_full_scan();
        test_sparse();
        test_zero_mask();
        test_hold_and_restart();
        test_abort();
        test_zero_settle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
